// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage of a simple in-order pipeline.
//
// Holds the program counter and the IF/ID pipeline register. A small
// three-state controller (IDLE / RUN / HALTED) sequences fetch:
//   IDLE   : PC parked at 0, IF/ID shows a bubble, waits for i_start.
//   RUN    : fetches one word per cycle. Priority is
//            stall > jump > halt > normal.
//   HALTED : entered after fetching HALT_INSTR; PC frozen. Only reset
//            leaves this state.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_reset          synchronous active-high reset
//   i_start          leave IDLE and start fetching from address 0
//   i_stall          hazard stall: hold PC and IF/ID
//   i_jump           redirect resolved in ID: load i_jump_addr, flush IF/ID
//   i_jump_addr      redirect target (low two bits dropped)
//   o_imem_addr      instruction memory address (the PC register)
//   i_imem_data      instruction word read combinationally at o_imem_addr
//   o_IF_ID_instr    registered instruction for ID
//   o_IF_ID_pc4      registered PC+4 of that instruction
//   o_IF_ID_valid    1 = real instruction, 0 = bubble
//   o_halted         fetch has stopped on HALT_INSTR
//   o_stall_cycles   stall-cycle performance counter
//   o_flush_count    jump-flush performance counter
//
// Configuration
//   IF_PERF_CNT_EN   when defined, the two performance counters are built
//                    (saturating at all-ones). When undefined, no counter
//                    state exists and both outputs are tied to zero.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned         NB_DATA    = 32,
    parameter logic [NB_DATA-1:0]  HALT_INSTR = {NB_DATA{1'b1}}
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [NB_DATA-1:0] i_jump_addr,
    output logic [NB_DATA-1:0] o_imem_addr,
    input  logic [NB_DATA-1:0] i_imem_data,
    output logic [NB_DATA-1:0] o_IF_ID_instr,
    output logic [NB_DATA-1:0] o_IF_ID_pc4,
    output logic               o_IF_ID_valid,
    output logic               o_halted,
    output logic [31:0]        o_stall_cycles,
    output logic [31:0]        o_flush_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic [NB_DATA-1:0] pc_plus4;

    // Plain modular add: 0x...FFFC + 4 wraps to 0 by design.
    assign pc_plus4 = pc_q + NB_DATA'(4);

    // ------------------------------------------------------------------
    // Next-state logic for the controller, PC and IF/ID register.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                // Stall and jump are meaningless before fetch has begun.
                pc_d    = '0;
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
                if (i_start) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                if (i_stall) begin
                    // Hold everything; a pending jump is re-presented by ID
                    // once the stall drops.
                end else if (i_jump) begin
                    // Targets are word aligned; the low bits are discarded.
                    pc_d    = {i_jump_addr[NB_DATA-1:2], 2'b00};
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (i_imem_data == HALT_INSTR) begin
                    // Pass the halt word down once, then freeze the PC.
                    instr_d = i_imem_data;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    state_d = StHalted;
                end else begin
                    pc_d    = pc_plus4;
                    instr_d = i_imem_data;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end

            StHalted: begin
                if (!i_stall) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
                pc_d    = '0;
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign o_imem_addr   = pc_q;
    assign o_IF_ID_instr = instr_q;
    assign o_IF_ID_pc4   = pc4_q;
    assign o_IF_ID_valid = valid_q;
    assign o_halted      = (state_q == StHalted);

    // ------------------------------------------------------------------
    // Performance counters.
    // ------------------------------------------------------------------
`ifdef IF_PERF_CNT_EN
    logic        stall_evt;
    logic        flush_evt;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Stall cycles only count once fetch is active; a flush is a jump that
    // actually redirected (i.e. was not masked by a stall).
    assign stall_evt = i_stall && ((state_q == StRun) || (state_q == StHalted));
    assign flush_evt = (state_q == StRun) && !i_stall && i_jump;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cycles = stall_cnt_q;
    assign o_flush_count  = flush_cnt_q;
`else
    assign o_stall_cycles = '0;
    assign o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A behavioural instruction memory returns addr + 0x100, or HALT_INSTR at
// 0x20 while halt_en is set. A table of per-cycle vectors covers reset,
// IDLE behaviour, sequential fetch, stall, jump, stall+jump and reset during
// a stall; hand-written sequences cover halting and PC wrap-around.
// Counter expectations follow IF_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        jump;
    logic [31:0] jump_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic        halt_en;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(
        .NB_DATA    (32),
        .HALT_INSTR (32'hFFFF_FFFF)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_stall        (stall),
        .i_jump         (jump),
        .i_jump_addr    (jump_addr),
        .o_imem_addr    (imem_addr),
        .i_imem_data    (imem_data),
        .o_IF_ID_instr  (if_id_instr),
        .o_IF_ID_pc4    (if_id_pc4),
        .o_IF_ID_valid  (if_id_valid),
        .o_halted       (halted),
        .o_stall_cycles (stall_cycles),
        .o_flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (halt_en && (imem_addr == 32'h20)) imem_data = 32'hFFFF_FFFF;
        else                                  imem_data = imem_addr + 32'h100;
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic        stall;
        logic        jump;
        logic [31:0] jaddr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic [31:0] scyc;
        logic [31:0] fcnt;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    // Counter expectation: real value with the counters built, else zero.
    function automatic logic [31:0] ce(input logic [31:0] v);
`ifdef IF_PERF_CNT_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic vec_t mk(input logic rst, input logic st, input logic sl,
                                input logic jp, input logic [31:0] ja,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic valid,
                                input logic hlt, input logic [31:0] sc,
                                input logic [31:0] fc);
        vec_t v;
        v.rst = rst;  v.start = st;  v.stall = sl;  v.jump = jp;  v.jaddr = ja;
        v.pc = pc;    v.instr = instr; v.pc4 = pc4; v.valid = valid;
        v.halted = hlt; v.scyc = ce(sc); v.fcnt = ce(fc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] pc4,
                             input logic valid, input logic hlt,
                             input logic [31:0] sc, input logic [31:0] fc);
        chk({tag, " pc"},     imem_addr,          pc);
        chk({tag, " instr"},  if_id_instr,        instr);
        chk({tag, " pc4"},    if_id_pc4,          pc4);
        chk({tag, " valid"},  32'(if_id_valid),   32'(valid));
        chk({tag, " halted"}, 32'(halted),        32'(hlt));
        chk({tag, " stall_cycles"}, stall_cycles, sc);
        chk({tag, " flush_count"},  flush_count,  fc);
    endtask

    // Drive one cycle of inputs, clock once, sample 1 ns after the edge.
    task automatic step(input logic rst, input logic st, input logic sl,
                        input logic jp, input logic [31:0] ja);
        reset = rst; start = st; stall = sl; jump = jp; jump_addr = ja;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0;
        jump_addr = 32'h0; halt_en = 1'b0;

        //             rst st sl jp jaddr          pc             instr          pc4            v  h  sc  fc
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 32'h80,        32'h0,         32'h0,         32'h0,         0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,         32'h4,         32'h100,       32'h4,         1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,         32'h8,         32'h104,       32'h8,         1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,         32'hC,         32'h108,       32'hC,         1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,         32'h10,        32'h10C,       32'h10,        1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 32'h0,         32'h10,        32'h10C,       32'h10,        1, 0, 1, 0);
        vecs[9]  = mk(0, 0, 1, 0, 32'h0,         32'h10,        32'h10C,       32'h10,        1, 0, 2, 0);
        vecs[10] = mk(0, 0, 1, 0, 32'h0,         32'h10,        32'h10C,       32'h10,        1, 0, 3, 0);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,         32'h14,        32'h110,       32'h14,        1, 0, 3, 0);
        vecs[12] = mk(0, 0, 0, 1, 32'h43,        32'h40,        32'h0,         32'h0,         0, 0, 3, 1);
        vecs[13] = mk(0, 0, 0, 0, 32'h0,         32'h44,        32'h140,       32'h44,        1, 0, 3, 1);
        vecs[14] = mk(0, 0, 1, 1, 32'h83,        32'h44,        32'h140,       32'h44,        1, 0, 4, 1);
        vecs[15] = mk(0, 0, 0, 1, 32'h83,        32'h80,        32'h0,         32'h0,         0, 0, 4, 2);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,         32'h84,        32'h180,       32'h84,        1, 0, 4, 2);
        vecs[17] = mk(1, 0, 1, 1, 32'h10,        32'h0,         32'h0,         32'h0,         0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].jump, vecs[i].jaddr);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc4,
                      vecs[i].valid, vecs[i].halted, vecs[i].scyc, vecs[i].fcnt);
        end

        // Halt at 0x20, stall while halted, then reset out of HALTED.
        halt_en = 1'b1;
        step(1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        check_all("halt start", 32'h0, 32'h0, 32'h0, 0, 0, ce(0), ce(0));
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 0, 32'h0);
            check_all($sformatf("halt fetch%0d", k), 32'(4 * k), 32'(32'h100 + 4 * (k - 1)),
                      32'(4 * k), 1, 0, ce(0), ce(0));
        end
        step(0, 0, 0, 0, 32'h0);
        check_all("halt word", 32'h20, 32'hFFFF_FFFF, 32'h24, 1, 1, ce(0), ce(0));
        step(0, 0, 1, 0, 32'h0);
        check_all("halt stall", 32'h20, 32'hFFFF_FFFF, 32'h24, 1, 1, ce(1), ce(0));
        step(0, 0, 0, 1, 32'h40);
        check_all("halt bubble1", 32'h20, 32'h0, 32'h0, 0, 1, ce(1), ce(0));
        step(0, 0, 0, 0, 32'h0);
        check_all("halt bubble2", 32'h20, 32'h0, 32'h0, 0, 1, ce(1), ce(0));
        step(1, 1, 0, 0, 32'h0);
        check_all("halt reset", 32'h0, 32'h0, 32'h0, 0, 0, ce(0), ce(0));
        step(0, 0, 0, 0, 32'h0);
        check_all("halt idle", 32'h0, 32'h0, 32'h0, 0, 0, ce(0), ce(0));

        // PC wrap: jump to the top word, then one normal fetch.
        halt_en = 1'b0;
        step(1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'hFFFF_FFFF);
        check_all("wrap jump", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, ce(0), ce(1));
        step(0, 0, 0, 0, 32'h0);
        check_all("wrap fetch", 32'h0, 32'h0000_00FC, 32'h0, 1, 0, ce(0), ce(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
